frame_sequencer: RTL and testbench

Per-frame controller for the pixel shader array. On a `start` pulse it fetches voxels one at a time from voxel memory and broadcasts each one to every shader with a `do_rasterize` handshake. It then runs one `do_shade` pass, scans the shared `row`/`col`-addressed pixel bus in raster order, and emits the pixels as a valid/ready stream toward the framebuffer writer.

---
 rtl/frame_seq_pkg.sv | 30 +++
 rtl/raster_scan_counter.sv | 46 ++++
 rtl/frame_sequencer.sv | 156 +++++++++++++++
 tb/tb_frame_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared types for the frame sequencer and its helpers.
// State encoding, voxel record layout and memory word width.
package frame_seq_pkg;

  localparam int VOX_COORD_BITS   = 8;
  localparam int VOX_PALETTE_BITS = 8;
  localparam int VOX_RDATA_BITS   =
    3 * VOX_COORD_BITS + VOX_PALETTE_BITS;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_WAIT_DATA = 4'd2,
    ST_RAST_REQ  = 4'd3,
    ST_RAST_GAP  = 4'd4,
    ST_SHADE_REQ = 4'd5,
    ST_SHADE_GAP = 4'd6,
    ST_READ_ADDR = 4'd7,
    ST_READ_HOLD = 4'd8,
    ST_DONE      = 4'd9
  } frame_state_t;

  typedef struct packed {
    logic [VOX_COORD_BITS-1:0]   x;
    logic [VOX_COORD_BITS-1:0]   y;
    logic [VOX_COORD_BITS-1:0]   z;
    logic [VOX_PALETTE_BITS-1:0] id;
  } voxel_t;

endpackage

// File: rtl/raster_scan_counter.sv
// Row/column raster counter with clear, advance and last flag.
// Wraps to (0,0) when advanced past the final position.
module raster_scan_counter #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 8
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_clear,
  input  logic                i_advance,
  output logic [ROW_BITS-1:0] o_row,
  output logic [COL_BITS-1:0] o_col,
  output logic                o_last
);

  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;
  logic                w_col_end;
  logic                w_row_end;

  assign w_col_end = (r_col == COL_BITS'(COLS - 1));
  assign w_row_end = (r_row == ROW_BITS'(ROWS - 1));
  assign o_last    = w_col_end && w_row_end;
  assign o_row     = r_row;
  assign o_col     = r_col;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: voxel broadcast, shade pass, raster readout.
// All outputs come from registers or the state register alone.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 8,
  parameter int COORD_BITS      = VOX_COORD_BITS,
  parameter int PALETTE_BITS    = VOX_PALETTE_BITS,
  parameter int PIXEL_BITS      = 8,
  parameter int VOXEL_ADDR_BITS = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [VOXEL_ADDR_BITS:0]     num_voxels,
  output logic                         voxel_rd,
  output logic [VOXEL_ADDR_BITS-1:0]   voxel_addr,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0] voxel_rdata,
  output logic [COORD_BITS-1:0]        voxel_x,
  output logic [COORD_BITS-1:0]        voxel_y,
  output logic [COORD_BITS-1:0]        voxel_z,
  output logic [PALETTE_BITS-1:0]      voxel_id,
  output logic                         do_rasterize,
  input  logic                         rasterizing_done_all,
  output logic                         do_shade,
  input  logic                         shading_done_all,
  output logic [ROW_BITS-1:0]          row,
  output logic [COL_BITS-1:0]          col,
  input  logic [PIXEL_BITS-1:0]        pixel,
  output logic [PIXEL_BITS-1:0]        pixel_out,
  output logic                         pixel_valid,
  input  logic                         pixel_ready,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int VA = VOXEL_ADDR_BITS;
  localparam logic [VA:0] MAX_VOX = {1'b1, {VA{1'b0}}};

  frame_state_t          r_state;
  logic [VA:0]           r_cnt;
  logic [VA:0]           r_idx;
  logic [COORD_BITS-1:0] r_vx;
  logic [COORD_BITS-1:0] r_vy;
  logic [COORD_BITS-1:0] r_vz;
  logic [PALETTE_BITS-1:0] r_vid;
  logic [PIXEL_BITS-1:0] r_pix;
  logic                  r_pvalid;

  logic [VA:0] w_cnt;
  logic        w_clear;
  logic        w_advance;
  logic        w_last;

  assign w_cnt = (num_voxels > MAX_VOX) ? MAX_VOX : num_voxels;

  assign w_clear   = (r_state == ST_SHADE_GAP)
                   && !shading_done_all;
  assign w_advance = (r_state == ST_READ_HOLD)
                   && pixel_ready;

  raster_scan_counter #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_scan (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_row     (row),
    .o_col     (col),
    .o_last    (w_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_vx     <= '0;
      r_vy     <= '0;
      r_vz     <= '0;
      r_vid    <= '0;
      r_pix    <= '0;
      r_pvalid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= w_cnt;
            r_idx   <= '0;
            r_state <= (num_voxels == '0) ?
                       ST_SHADE_REQ : ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_WAIT_DATA;
        ST_WAIT_DATA: begin
          {r_vx, r_vy, r_vz, r_vid} <= voxel_rdata;
          r_state <= ST_RAST_REQ;
        end
        ST_RAST_REQ: begin
          if (rasterizing_done_all) begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_RAST_GAP;
          end
        end
        // Leaving only once done is low keeps the next request clean.
        ST_RAST_GAP: begin
          if (!rasterizing_done_all)
            r_state <= (r_idx < r_cnt) ?
                       ST_FETCH : ST_SHADE_REQ;
        end
        ST_SHADE_REQ: begin
          if (shading_done_all)
            r_state <= ST_SHADE_GAP;
        end
        ST_SHADE_GAP: begin
          if (!shading_done_all)
            r_state <= ST_READ_ADDR;
        end
        ST_READ_ADDR: begin
          r_pix    <= pixel;
          r_pvalid <= 1'b1;
          r_state  <= ST_READ_HOLD;
        end
        ST_READ_HOLD: begin
          if (pixel_ready) begin
            r_pvalid <= 1'b0;
            r_state  <= w_last ? ST_DONE : ST_READ_ADDR;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign voxel_rd     = (r_state == ST_FETCH);
  assign voxel_addr   = r_idx[VA-1:0];
  assign voxel_x      = r_vx;
  assign voxel_y      = r_vy;
  assign voxel_z      = r_vz;
  assign voxel_id     = r_vid;
  assign do_rasterize = (r_state == ST_RAST_REQ);
  assign do_shade     = (r_state == ST_SHADE_REQ);
  assign pixel_out    = r_pix;
  assign pixel_valid  = r_pvalid;
  assign busy         = (r_state != ST_IDLE);
  assign frame_done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with shader, memory
// and pixel bus models.
module tb_frame_sequencer;
  import frame_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] num_voxels = '0;
  logic        voxel_rd;
  logic [9:0]  voxel_addr;
  logic [31:0] voxel_rdata = '0;
  logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id;
  logic        do_rasterize;
  logic        rasterizing_done_all;
  logic        do_shade;
  logic        shading_done_all;
  logic [7:0]  row, col;
  logic [7:0]  pixel;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic        pixel_ready = 1'b1;
  logic        busy;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  frame_sequencer dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .num_voxels           (num_voxels),
    .voxel_rd             (voxel_rd),
    .voxel_addr           (voxel_addr),
    .voxel_rdata          (voxel_rdata),
    .voxel_x              (voxel_x),
    .voxel_y              (voxel_y),
    .voxel_z              (voxel_z),
    .voxel_id             (voxel_id),
    .do_rasterize         (do_rasterize),
    .rasterizing_done_all (rasterizing_done_all),
    .do_shade             (do_shade),
    .shading_done_all     (shading_done_all),
    .row                  (row),
    .col                  (col),
    .pixel                (pixel),
    .pixel_out            (pixel_out),
    .pixel_valid          (pixel_valid),
    .pixel_ready          (pixel_ready),
    .busy                 (busy),
    .frame_done           (frame_done)
  );

  voxel_t mem [4];

  always @(posedge clock)
    if (voxel_rd) voxel_rdata <= mem[voxel_addr[1:0]];

  assign pixel = 8'(row * 8'd16 + col);

  // Shader array: done in the 3rd request cycle, optional hold.
  int rc = 0;
  int hold = 0;
  int hold_extra = 0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rc <= 0;
      hold <= 0;
      rasterizing_done_all <= 1'b0;
    end else if (do_rasterize) begin
      rc <= rc + 1;
      if (rc == 1) begin
        rasterizing_done_all <= 1'b1;
        hold <= hold_extra;
      end
    end else begin
      rc <= 0;
      if (hold != 0) hold <= hold - 1;
      else rasterizing_done_all <= 1'b0;
    end
  end

  int sc = 0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sc <= 0;
      shading_done_all <= 1'b0;
    end else if (do_shade) begin
      sc <= sc + 1;
      if (sc == 1) shading_done_all <= 1'b1;
    end else begin
      sc <= 0;
      shading_done_all <= 1'b0;
    end
  end

  // Monitor
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int done_cnt = 0, shade_cnt = 0, viol = 0;
  int hi = 0, lo = 0;
  logic have_fall = 1'b0;
  logic p_rast = 1'b0, p_shade = 1'b0;
  logic p_valid = 1'b0, p_ready = 1'b0;
  logic [7:0]  p_pix = '0;
  logic [31:0] p_vox = '0;
  logic [9:0]  rd_addrs [$];
  logic [31:0] rast_log [$];
  int          rast_len [$];
  int          gaps [$];
  logic [7:0]  pix [$];

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (start && !busy) start_cyc <= cyc;
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (voxel_rd) rd_addrs.push_back(voxel_addr);
    if (do_rasterize) begin
      hi <= p_rast ? hi + 1 : 1;
      if (!p_rast) begin
        rast_log.push_back({voxel_x, voxel_y, voxel_z, voxel_id});
        if (have_fall) gaps.push_back(lo);
      end else if ({voxel_x, voxel_y, voxel_z, voxel_id} != p_vox)
        viol <= viol + 1;
    end else begin
      lo <= p_rast ? 1 : lo + 1;
      if (p_rast) begin
        rast_len.push_back(hi);
        have_fall <= 1'b1;
      end
    end
    if (do_shade && !p_shade) shade_cnt <= shade_cnt + 1;
    if (do_shade && do_rasterize) viol <= viol + 1;
    if (pixel_valid && pixel_ready) pix.push_back(pixel_out);
    if (p_valid && !p_ready &&
        (!pixel_valid || pixel_out != p_pix))
      viol <= viol + 1;
    p_rast  <= do_rasterize;
    p_shade <= do_shade;
    p_valid <= pixel_valid;
    p_ready <= pixel_ready;
    p_pix   <= pixel_out;
    p_vox   <= {voxel_x, voxel_y, voxel_z, voxel_id};
  end

  logic rand_ready = 1'b0;
  initial forever begin
    @(posedge clock);
    #1;
    if (rand_ready) pixel_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [10:0] n);
    num_voxels = n;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    chk("frame_done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic clear_logs();
    rd_addrs.delete();
    rast_log.delete();
    rast_len.delete();
    gaps.delete();
    pix.delete();
  endtask

  task automatic chk_pixels(input string tag);
    chk({tag, "_count"}, 32'(pix.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_pix%0d", tag, i),
          32'(pix[i]), 32'((i / 4) * 16 + (i % 4)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  int sh0;

  initial begin
    mem[0] = '{x: 8'h11, y: 8'h12, z: 8'h13, id: 8'hA0};
    mem[1] = '{x: 8'h21, y: 8'h22, z: 8'h23, id: 8'hB1};
    mem[2] = '{x: 8'h31, y: 8'h32, z: 8'h33, id: 8'hC2};
    mem[3] = '{x: 8'h41, y: 8'h42, z: 8'h43, id: 8'hD3};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rast", 32'(do_rasterize), 0);
    chk("rst_shade", 32'(do_shade), 0);
    chk("rst_rd", 32'(voxel_rd), 0);
    chk("rst_addr", 32'(voxel_addr), 0);
    chk("rst_rowcol", {16'd0, row, col}, 0);
    chk("rst_vox", {voxel_x, voxel_y, voxel_z, voxel_id}, 0);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_done", 32'(frame_done), 0);
    tick(1);
    reset = 1'b1;
    tick(2);

    // Three voxels, ready always high
    clear_logs();
    base = done_cnt;
    sh0 = shade_cnt;
    pulse_start(11'd3);
    wait_done(base + 1, 500);
    tick(3);
    chk("n3_rd_count", 32'(rd_addrs.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("n3_addr%0d", i), 32'(rd_addrs[i]), 32'(i));
      chk($sformatf("n3_vox%0d", i), rast_log[i], mem[i]);
      chk($sformatf("n3_rlen%0d", i), 32'(rast_len[i]), 3);
    end
    chk("n3_shade_once", 32'(shade_cnt - sh0), 1);
    chk("n3_frame_cycles", 32'(done_cyc - start_cyc), 59);
    chk("n3_gap", 32'(gaps[$]), 4);
    chk_pixels("n3");

    // Zero voxels
    clear_logs();
    base = done_cnt;
    pulse_start(11'd0);
    chk("n0_shade_early", 32'(do_shade), 1);
    chk("n0_busy", 32'(busy), 1);
    wait_done(base + 1, 500);
    tick(2);
    chk("n0_no_rd", 32'(rd_addrs.size()), 0);
    chk("n0_frame_cycles", 32'(done_cyc - start_cyc), 38);
    chk_pixels("n0");

    // Random backpressure on the pixel stream
    clear_logs();
    base = done_cnt;
    rand_ready = 1'b1;
    pulse_start(11'd0);
    wait_done(base + 1, 1000);
    rand_ready = 1'b0;
    tick(1);
    pixel_ready = 1'b1;
    chk_pixels("rnd");

    // Done held 4 extra cycles after request drops
    clear_logs();
    base = done_cnt;
    hold_extra = 4;
    pulse_start(11'd2);
    wait_done(base + 1, 800);
    hold_extra = 0;
    tick(2);
    chk("hold_rd_count", 32'(rd_addrs.size()), 2);
    chk("hold_gap", 32'(gaps[$]), 8);
    chk("hold_vox1", rast_log[1], mem[1]);

    // Asynchronous reset during the second rasterize request
    clear_logs();
    base = done_cnt;
    pulse_start(11'd2);
    begin
      int n = 0;
      while (rast_log.size() < 2 && n < 200) begin
        tick(1);
        n++;
      end
    end
    chk("ar_in_rast", 32'(do_rasterize), 1);
    chk("ar_addr_pre", 32'(voxel_addr), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_rast", 32'(do_rasterize), 0);
    chk("ar_shade", 32'(do_shade), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_addr", 32'(voxel_addr), 0);
    chk("ar_vox", {voxel_x, voxel_y, voxel_z, voxel_id}, 0);
    tick(2);
    reset = 1'b1;
    tick(5);
    chk("ar_no_done", 32'(done_cnt), 32'(base));
    chk("ar_idle", 32'(busy), 0);

    // Start while busy is dropped
    clear_logs();
    base = done_cnt;
    pulse_start(11'd1);
    tick(3);
    pulse_start(11'd3);
    wait_done(base + 1, 500);
    tick(150);
    chk("bs_one_done", 32'(done_cnt), 32'(base + 1));
    chk("bs_rd_count", 32'(rd_addrs.size()), 1);
    chk("bs_idle", 32'(busy), 0);

    // Voxel count saturation
    clear_logs();
    base = done_cnt;
    pulse_start(11'd2047);
    wait_done(base + 1, 20000);
    tick(2);
    chk("sat_rd_count", 32'(rd_addrs.size()), 1024);
    chk("sat_last_addr", 32'(rd_addrs[$]), 1023);
    chk("sat_last_vox", rast_log[$], mem[3]);
    chk("monitor_viol", 32'(viol), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
